// File: rtl/reg_bank_arbiter_pkg.sv
// Shared types and defaults for the register-bank arbiter slice.
// Latency: n/a (types only). Backpressure: n/a.
package reg_bank_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    localparam int DEF_NUM_REQ     = 2;
    localparam int DEF_ADDR_W      = 8;
    localparam int DEF_REG_W       = 8;
    localparam int DEF_NUM_REGS    = 8;
    localparam int DEF_TIMEOUT_CYC = 15;

    // A timeout of 0 means wait forever; keep at least one counter bit so widths stay legal.
    function automatic int cnt_width(input int cyc);
        return (cyc > 0) ? $clog2(cyc + 1) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request strictly after index 'last', wrapping.
// Latency: purely combinational. Backpressure: none, the pointer is owned by the caller.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx
);
    localparam int IDX_W = $clog2(N);

    logic             found;
    int               sum;
    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        sum     = 0;
        cand    = '0;
        for (int off = 1; off <= N; off++) begin
            sum = int'(last) + off;
            if (sum >= N) begin
                sum = sum - N;
            end
            cand = IDX_W'(sum);
            if (!found && req[cand]) begin
                found      = 1'b1;
                gnt[cand]  = 1'b1;
                gnt_idx    = cand;
            end
        end
    end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Shares one register-bank port between NUM_REQ requesters: round robin, range check, ack timeout.
// Latency: 2 cycles request->rsp_valid with bank_ack tied 1, 1 cycle for out-of-range addresses.
// Backpressure: one access in flight; other requesters hold req_valid and wait, never dropped.
module reg_bank_arbiter
    import reg_bank_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int REG_W       = DEF_REG_W,
    parameter int NUM_REGS    = DEF_NUM_REGS,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_wr_rdn,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*REG_W-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [REG_W-1:0]          rsp_rdata,
    output logic                      rsp_err,
    output logic                      busy,
    output logic                      bank_ena,
    output logic                      bank_we,
    output logic                      bank_wr_rdn,
    output logic [ADDR_W-1:0]         bank_addr,
    output logic [REG_W-1:0]          bank_wdata,
    input  logic [REG_W-1:0]          bank_rdata,
    input  logic                      bank_ack,
    input  logic                      bank_err
);
    localparam int                IDX_W      = $clog2(NUM_REQ);
    localparam int                CNT_W      = cnt_width(TIMEOUT_CYC);
    localparam logic [ADDR_W:0]   ADDR_LIMIT = (ADDR_W + 1)'(NUM_REGS);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    arb_state_t         state;
    arb_state_t         state_nxt;
    logic [IDX_W-1:0]   ptr_q;
    logic [IDX_W-1:0]   idx_q;
    logic               wr_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [REG_W-1:0]   wdata_q;
    logic [REG_W-1:0]   rdata_q;
    logic               err_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               sel_wr;
    logic [ADDR_W-1:0]  sel_addr;
    logic [REG_W-1:0]   sel_wdata;
    logic               req_any;
    logic               sel_oor;
    logic               timeout_hit;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req     (req_valid),
        .last    (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        sel_wr    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_wr    = req_wr_rdn[i];
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*REG_W +: REG_W];
            end
        end
    end

    assign req_any     = |req_valid;
    assign sel_oor     = {1'b0, sel_addr} >= ADDR_LIMIT;
    assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == CNT_LAST);

    assign rsp_rdata  = rdata_q;
    assign rsp_err    = err_q;
    assign bank_addr  = addr_q;
    assign bank_wdata = wdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Strobes decode straight from state so an asynchronous reset drops bank_we at once.
    always_comb begin
        state_nxt   = state;
        busy        = (state != IDLE);
        bank_ena    = 1'b0;
        bank_we     = 1'b0;
        bank_wr_rdn = 1'b0;
        rsp_valid   = '0;
        case (state)
            IDLE: begin
                if (req_any) begin
                    state_nxt = sel_oor ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                bank_ena    = 1'b1;
                bank_we     = wr_q;
                bank_wr_rdn = wr_q;
                if (bank_ack || timeout_hit) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    rsp_valid[i] = (idx_q == IDX_W'(i));
                end
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= IDX_W'(NUM_REQ - 1);
            idx_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_any) begin
                        ptr_q   <= gnt_idx;
                        idx_q   <= gnt_idx;
                        wr_q    <= sel_wr;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        cnt_q   <= '0;
                        if (sel_oor) begin
                            rdata_q <= '0;
                            err_q   <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    // An ack on the expiry cycle still completes the access normally.
                    if (bank_ack) begin
                        rdata_q <= wr_q ? '0 : bank_rdata;
                        err_q   <= bank_err;
                    end else if (timeout_hit) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
